credit_tx: RTL

- Transmit end of the team's valid/ready pipe protocol, used when the receiving pipe is remote or behind a pipeline of registers and cannot drive a same-cycle ready back.
- Accepts words on a local enqueue handshake and forwards them as valid-only beats over a registered link.
- Tracks free slots in the remote receive pipe with a credit counter; the receiver returns one credit per dequeued word.
- Provides a drain sequence so software or control logic can quiesce the link.

---
 rtl/credit_tx.sv | 121 ++++++++++++
 1 files changed

// File: rtl/credit_tx.sv
// Credit-based transmit end of the valid/ready pipe: a local enqueue handshake feeds
// registered valid-only link beats, gated by a count of free slots in the remote receiver.
module credit_tx #(
   parameter int DATA_SIZE = 1,
   parameter int CREDITS   = 4,
   parameter int CNT_W     = $clog2(CREDITS + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_SIZE-1:0] enq_data,
   input  logic                 enq_valid,
   output logic                 enq_ready,
   output logic [DATA_SIZE-1:0] tx_data,
   output logic                 tx_valid,
   input  logic                 credit_ret,
   input  logic                 drain_req,
   output logic                 drain_done,
   output logic [CNT_W-1:0]     credit_cnt,
   output logic                 err_overflow
);

   localparam logic [CNT_W-1:0] CREDITS_FULL = CNT_W'(CREDITS);

   typedef enum logic [1:0] {
      S_INIT,
      S_RUN,
      S_DRAIN,
      S_WAIT_REL
   } state_t;

   state_t                 state_reg, state_next;
   logic [CNT_W-1:0]       credit_cnt_reg, credit_cnt_next;
   logic                   tx_valid_reg, tx_valid_next;
   logic [DATA_SIZE-1:0]   tx_data_reg, tx_data_next;
   logic                   drain_done_reg, drain_done_next;
   logic                   err_overflow_reg, err_overflow_next;
   logic                   enq_ready_c;
   logic                   accept;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= S_INIT;
         credit_cnt_reg   <= CREDITS_FULL;
         tx_valid_reg     <= 1'b0;
         tx_data_reg      <= '0;
         drain_done_reg   <= 1'b0;
         err_overflow_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         credit_cnt_reg   <= credit_cnt_next;
         tx_valid_reg     <= tx_valid_next;
         tx_data_reg      <= tx_data_next;
         drain_done_reg   <= drain_done_next;
         err_overflow_reg <= err_overflow_next;
      end
   end

   // enq_ready depends only on registers and drain_req, never on enq_valid.
   always_comb begin
      state_next      = state_reg;
      enq_ready_c     = 1'b0;
      drain_done_next = 1'b0;
      unique case (state_reg)
         S_INIT: begin
            state_next = S_RUN;
         end
         S_RUN: begin
            enq_ready_c = (credit_cnt_reg != '0) && !drain_req;
            if (drain_req) begin
               state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (credit_cnt_reg == CREDITS_FULL) begin
               drain_done_next = 1'b1;
               state_next      = S_WAIT_REL;
            end
         end
         S_WAIT_REL: begin
            if (!drain_req) begin
               state_next = S_RUN;
            end
         end
         default: begin
            state_next = S_INIT;
         end
      endcase
   end

   assign accept = enq_valid && enq_ready_c;

   always_comb begin
      credit_cnt_next   = credit_cnt_reg;
      err_overflow_next = err_overflow_reg;
      tx_valid_next     = accept;
      tx_data_next      = tx_data_reg;
      if (accept) begin
         tx_data_next = enq_data;
      end
      // A simultaneous accept and return cancel out, even at full count.
      unique case ({accept, credit_ret})
         2'b10: credit_cnt_next = credit_cnt_reg - 1'b1;
         2'b01: begin
            if (credit_cnt_reg == CREDITS_FULL) begin
               err_overflow_next = 1'b1;
            end else begin
               credit_cnt_next = credit_cnt_reg + 1'b1;
            end
         end
         default: credit_cnt_next = credit_cnt_reg;
      endcase
   end

   assign enq_ready    = enq_ready_c;
   assign tx_valid     = tx_valid_reg;
   assign tx_data      = tx_data_reg;
   assign drain_done   = drain_done_reg;
   assign credit_cnt   = credit_cnt_reg;
   assign err_overflow = err_overflow_reg;

endmodule
